// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster stream, with row/col tracking, border gating and broken-stream detection.
// Optional: define CONV3X3_RELU_EN to clamp negative window sums to zero at the output stage.
module conv3x3_stream #(
    parameter  int N  = 16,
    parameter  int W  = 28,
    parameter  int H  = 28,
    localparam int OW = 2*N + 4
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iValid,
    input  logic [N-1:0]  iData,
    input  logic [N-1:0]  iLine1,
    input  logic [N-1:0]  iLine2,
    input  logic          iWeightWe,
    input  logic [3:0]    iWeightAddr,
    input  logic [N-1:0]  iWeightData,
    output logic          oValid,
    output logic [OW-1:0] oData,
    output logic          oFrameDone,
    output logic          oErr
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;

    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic signed [N-1:0]    wgt  [9];
    logic signed [N-1:0]    win  [3][3];
    logic signed [2*N-1:0]  prod [9];
    logic signed [OW-1:0]   sum;
    logic                   v1, v2, last1, last2;
    logic                   active, flush, last_col, last_row, interior;

    assign active   = (row != '0) || (col != '0);
    assign flush    = !iValid && active;
    assign last_col = (col == CW'(W-1));
    assign last_row = (row == RW'(H-1));
    assign interior = (row >= RW'(2)) && (col >= CW'(2));

    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++)
            sum = sum + $signed({{4{prod[k][2*N-1]}}, prod[k]});
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            col        <= '0;
            row        <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            last1      <= 1'b0;
            last2      <= 1'b0;
            oValid     <= 1'b0;
            oData      <= '0;
            oFrameDone <= 1'b0;
            oErr       <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                wgt[k]  <= '0;
                prod[k] <= '0;
            end
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win[i][j] <= '0;
        end else begin
            oErr <= flush;
            if (iValid) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                // Column 2 is the newest; row 0 is the oldest line (r-2).
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= iLine2;
                win[1][2] <= iLine1;
                win[2][2] <= iData;
                v1    <= interior;
                last1 <= last_row && last_col;
            end else begin
                v1    <= 1'b0;
                last1 <= 1'b0;
                if (active) begin
                    col <= '0;
                    row <= '0;
                end
            end

            if (iWeightWe && !iValid && !active && (iWeightAddr < 4'd9))
                wgt[iWeightAddr] <= iWeightData;

            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    prod[3*i+j] <= win[i][j] * wgt[3*i+j];

            // A broken stream kills every result still travelling down the pipe.
            v2         <= v1 && !flush;
            last2      <= last1 && !flush;
            oValid     <= v2 && !flush;
            oFrameDone <= last2 && !flush;
            if (v2 && !flush) begin
`ifdef CONV3X3_RELU_EN
                oData <= sum[OW-1] ? '0 : sum;
`else
                oData <= sum;
`endif
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream: directed and random frames against a window-sum reference model.
// The reference clamps negative sums when CONV3X3_RELU_EN is defined, matching the build under test.
module tb_conv3x3_stream;
    localparam int N    = 16;
    localparam int W    = 28;
    localparam int H    = 28;
    localparam int OW   = 2*N + 4;
    localparam int NPIX = W*H;

    logic          iCLK = 1'b0;
    logic          iRST, iValid, iWeightWe;
    logic [N-1:0]  iData, iLine1, iLine2, iWeightData;
    logic [3:0]    iWeightAddr;
    logic          oValid, oFrameDone, oErr;
    logic [OW-1:0] oData;

    int checks = 0;
    int errors = 0;
    int img [NPIX];
    int wt  [9];

    conv3x3_stream #(.N(N), .W(W), .H(H)) dut (
        .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iData(iData),
        .iLine1(iLine1), .iLine2(iLine2), .iWeightWe(iWeightWe),
        .iWeightAddr(iWeightAddr), .iWeightData(iWeightData),
        .oValid(oValid), .oData(oData), .oFrameDone(oFrameDone), .oErr(oErr)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_w(input int k, input int v);
        iValid      = 1'b0;
        iWeightWe   = 1'b1;
        iWeightAddr = 4'(k);
        iWeightData = N'(v);
        step();
        iWeightWe   = 1'b0;
    endtask

    task automatic load_weights();
        for (int k = 0; k < 9; k++) set_w(k, wt[k]);
        set_w(9, int'($urandom));
        set_w(15, int'($urandom));
    endtask

    function automatic longint model(input int t);
        int r, c;
        longint s;
        r = t / W;
        c = t % W;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += longint'(wt[3*i+j]) * longint'(img[(r-2+i)*W + (c-2+j)]);
`ifdef CONV3X3_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic run_frame(input int drop_at, input string tag);
        bit     ev   [NPIX+4];
        longint ed   [NPIX+4];
        bit     efd  [NPIX+4];
        bit     eerr [NPIX+4];
        int     n_in, nv, nfd;
        for (int s = 0; s < NPIX+4; s++) begin
            ev[s] = 0; ed[s] = 0; efd[s] = 0; eerr[s] = 0;
        end
        n_in = (drop_at >= 0) ? drop_at : NPIX;
        for (int t = 0; t < n_in; t++) begin
            if ((t / W) >= 2 && (t % W) >= 2 && (drop_at < 0 || t + 3 <= drop_at)) begin
                ev[t+2]  = 1;
                ed[t+2]  = model(t);
                efd[t+2] = (t == NPIX-1);
            end
        end
        if (drop_at >= 0) eerr[drop_at] = 1;
        nv = 0;
        nfd = 0;
        for (int s = 0; s < n_in + 4; s++) begin
            iValid = (s < n_in);
            if (s < NPIX) begin
                iData  = N'(img[s]);
                iLine1 = (s >= W)   ? N'(img[s-W])   : N'($urandom);
                iLine2 = (s >= 2*W) ? N'(img[s-2*W]) : N'($urandom);
            end else begin
                iData  = N'($urandom);
                iLine1 = N'($urandom);
                iLine2 = N'($urandom);
            end
            iWeightWe   = (s == n_in/2) || (s == drop_at);
            iWeightAddr = 4'($urandom_range(0, 8));
            iWeightData = N'($urandom);
            step();
            check($sformatf("%s valid s=%0d", tag, s), oValid, ev[s]);
            check($sformatf("%s done s=%0d", tag, s), oFrameDone, efd[s]);
            check($sformatf("%s err s=%0d", tag, s), oErr, eerr[s]);
            if (ev[s]) check($sformatf("%s data s=%0d", tag, s), oData, ed[s]);
            nv  += int'(oValid);
            nfd += int'(oFrameDone);
        end
        iWeightWe = 1'b0;
        iValid    = 1'b0;
        if (drop_at < 0) begin
            check($sformatf("%s valid_count", tag), nv, (W-2)*(H-2));
            check($sformatf("%s done_count", tag), nfd, 1);
        end else begin
            check($sformatf("%s done_count", tag), nfd, 0);
        end
    endtask

    initial begin
        iRST = 1'b1; iValid = 1'b0; iWeightWe = 1'b0; iWeightAddr = '0;
        iWeightData = '0; iData = '0; iLine1 = '0; iLine2 = '0;
        repeat (2) step();
        check("rst valid", oValid, 0);
        check("rst data", oData, 0);
        check("rst done", oFrameDone, 0);
        check("rst err", oErr, 0);
        iRST = 1'b0;
        step();

        // all-ones weights and pixels
        for (int k = 0; k < 9; k++) wt[k] = 1;
        for (int t = 0; t < NPIX; t++) img[t] = 1;
        load_weights();
        run_frame(-1, "ones");

        // centre tap on a ramp image
        for (int k = 0; k < 9; k++) wt[k] = (k == 4) ? 1 : 0;
        for (int t = 0; t < NPIX; t++) img[t] = t;
        load_weights();
        run_frame(-1, "ramp");

        // negative sums
        for (int k = 0; k < 9; k++) wt[k] = -1;
        for (int t = 0; t < NPIX; t++) img[t] = 100;
        load_weights();
        run_frame(-1, "neg");

        // full-scale extremes
        for (int k = 0; k < 9; k++) wt[k] = -32768;
        for (int t = 0; t < NPIX; t++) img[t] = -32768;
        load_weights();
        run_frame(-1, "extreme");

        // random weights and pixels
        for (int k = 0; k < 9; k++) wt[k] = int'($signed(N'($urandom)));
        for (int t = 0; t < NPIX; t++) img[t] = int'($signed(N'($urandom)));
        load_weights();
        run_frame(-1, "random");

        // broken stream at (5,10), then a clean frame with unchanged weights
        for (int k = 0; k < 9; k++) wt[k] = 1;
        for (int t = 0; t < NPIX; t++) img[t] = 1;
        load_weights();
        run_frame(5*W + 10, "drop");
        run_frame(-1, "after_drop");

        // reset in the middle of a stream with random weights loaded
        for (int k = 0; k < 9; k++) wt[k] = int'($signed(N'($urandom)));
        load_weights();
        for (int s = 0; s < 100; s++) begin
            iValid = 1'b1;
            iData  = N'($urandom) | 16'h0001;
            iLine1 = N'($urandom);
            iLine2 = N'($urandom);
            step();
        end
        iRST = 1'b1;
        step();
        check("midrst valid", oValid, 0);
        check("midrst data", oData, 0);
        check("midrst done", oFrameDone, 0);
        check("midrst err", oErr, 0);
        step();
        iRST = 1'b0;
        iValid = 1'b0;
        step();
        for (int k = 0; k < 9; k++) wt[k] = 0;
        for (int t = 0; t < NPIX; t++) img[t] = int'($signed(N'($urandom)));
        run_frame(-1, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
